note_spawner: RTL and testbench

Generates the timed stream of arrow-spawn events for one song run, at a rate set by the difficulty chosen upstream by the difficulty selector. Sits directly downstream of the selector: `difficulty` is latched at run start. Lanes come from an LFSR, and each event is offered to the arrow renderer over a valid/ready handshake.

---
 rtl/dance_game_pkg.sv | 25 ++
 rtl/note_spawner_if.sv | 9 +
 rtl/lfsr16.sv | 21 ++
 rtl/note_spawner.sv | 105 ++++++++++
 tb/tb_note_spawner.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/dance_game_pkg.sv
// Shared types for the dance-game blocks: difficulty encodings, spawner states,
// and the 16-bit LFSR (taps 16,14,13,11) used for lane selection.
package dance_game_pkg;

   typedef enum logic [1:0] {
      DIFF_EASY   = 2'b00,
      DIFF_MEDIUM = 2'b01,
      DIFF_HARD   = 2'b10
   } difficulty_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_PRESENT = 2'd2,
      ST_DONE    = 2'd3
   } spawner_state_e;

   // Right-shift Fibonacci form: taps 16,14,13,11 map to bits 0,2,3,5.
   localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

   function automatic logic [15:0] lfsr_next(input logic [15:0] q);
      return {^(q & LFSR_TAP_MASK), q[15:1]};
   endfunction

endpackage

// File: rtl/note_spawner_if.sv
// Spawn-event handshake between the note spawner (master) and the arrow renderer.
interface note_spawner_if;
   logic       spawn_valid;
   logic       spawn_ready;
   logic [1:0] spawn_lane;

   modport master (output spawn_valid, output spawn_lane, input spawn_ready);
   modport slave  (input spawn_valid, input spawn_lane, output spawn_ready);
endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous seed load and single-step advance.
module lfsr16
   import dance_game_pkg::*;
#(
   parameter logic [15:0] RST_VAL = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        step,
   output logic [15:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    q <= RST_VAL;
      else if (load) q <= seed;
      else if (step) q <= lfsr_next(q);
   end

endmodule

// File: rtl/note_spawner.sv
// Timed arrow-spawn event generator for one song run; period latched from difficulty at start.
// NOTE_SPAWNER_NO_REPEAT_EN: forbid two consecutive accepted events on the same lane.
module note_spawner
   import dance_game_pkg::*;
#(
   parameter int          EASY_PERIOD   = 8,
   parameter int          MEDIUM_PERIOD = 6,
   parameter int          HARD_PERIOD   = 4,
   parameter int          NOTE_LIMIT    = 5,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic [1:0]            difficulty,
   note_spawner_if.master        spawn,
   output logic [15:0]           spawn_count,
   output logic                  active,
   output logic                  done
);

   spawner_state_e state;
   logic [15:0]    period;
   logic [15:0]    cnt;
   logic [15:0]    lfsr_q;
   logic [1:0]     lane;
   logic           start_ok;
   logic           accept;

   function automatic logic [15:0] period_of(input logic [1:0] d);
      case (d)
         DIFF_EASY:   return 16'(EASY_PERIOD);
         DIFF_MEDIUM: return 16'(MEDIUM_PERIOD);
         default:     return 16'(HARD_PERIOD);
      endcase
   endfunction

   assign start_ok = start && !stop && (state == ST_IDLE || state == ST_DONE);
   // stop kills the offer combinationally, so a same-cycle ready is never a handshake
   assign spawn.spawn_valid = (state == ST_PRESENT) && !stop;
   assign spawn.spawn_lane  = spawn.spawn_valid ? lane : 2'd0;
   assign accept            = spawn.spawn_valid && spawn.spawn_ready;
   assign active            = (state == ST_WAIT) || (state == ST_PRESENT);
   assign done              = (state == ST_DONE);

   lfsr16 #(.RST_VAL(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (start_ok),
      .seed  (LFSR_SEED),
      .step  (accept),
      .q     (lfsr_q)
   );

`ifdef NOTE_SPAWNER_NO_REPEAT_EN
   logic [1:0] prev_lane;

   assign lane = (lfsr_q[1:0] == prev_lane) ? lfsr_q[1:0] + 2'd1 : lfsr_q[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        prev_lane <= 2'd0;
      else if (start_ok) prev_lane <= 2'd0;
      else if (accept)   prev_lane <= lane;
   end
`else
   assign lane = lfsr_q[1:0];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         period      <= 16'd0;
         cnt         <= 16'd0;
         spawn_count <= 16'd0;
      end else if (stop) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: if (start) begin
               period      <= period_of(difficulty);
               cnt         <= period_of(difficulty) - 16'd1;
               spawn_count <= 16'd0;
               state       <= ST_WAIT;
            end
            ST_WAIT: begin
               if (cnt == 16'd0) state <= ST_PRESENT;
               else              cnt   <= cnt - 16'd1;
            end
            ST_PRESENT: if (accept) begin
               spawn_count <= spawn_count + 16'd1;
               if (spawn_count + 16'd1 == 16'(NOTE_LIMIT)) begin
                  state <= ST_DONE;
               end else begin
                  // the accepting cycle counts toward the next period
                  cnt   <= period - 16'd2;
                  state <= ST_WAIT;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_note_spawner.sv
// Directed bench for note_spawner: timing, stall, stop, reset, and a 1000-event lane run.
module tb_note_spawner;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, stop;
   logic [1:0]  difficulty;
   logic [15:0] spawn_count;
   logic        active, done;

   logic        l_start;
   logic [15:0] l_count;
   logic        l_active, l_done;

   int n_chk = 0;
   int n_err = 0;

   note_spawner_if sif ();
   note_spawner_if lsif ();

   always #5 clk = ~clk;

   note_spawner dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stop        (stop),
      .difficulty  (difficulty),
      .spawn       (sif),
      .spawn_count (spawn_count),
      .active      (active),
      .done        (done)
   );

   note_spawner #(.NOTE_LIMIT(1000)) u_long (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (l_start),
      .stop        (1'b0),
      .difficulty  (2'b10),
      .spawn       (lsif),
      .spawn_count (l_count),
      .active      (l_active),
      .done        (l_done)
   );

   // Hand-derived first five lanes from seed 16'hACE1 (raw sequence 1,0,0,0,2).
   logic [1:0] lanes [5];
   initial begin
`ifdef NOTE_SPAWNER_NO_REPEAT_EN
      lanes[0] = 2'd1; lanes[1] = 2'd0; lanes[2] = 2'd1; lanes[3] = 2'd0; lanes[4] = 2'd2;
`else
      lanes[0] = 2'd1; lanes[1] = 2'd0; lanes[2] = 2'd0; lanes[3] = 2'd0; lanes[4] = 2'd2;
`endif
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_start(input logic [1:0] d);
      difficulty = d;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Long-run lane monitor: reference LFSR written directly from the tap list.
   logic [15:0] m;
   logic [1:0]  m_prev, m_exp, last_lane;
   int          n_seen = 0;
   int          lane_bad = 0;

   always @(negedge clk) begin
      if (l_start) begin
         m = 16'hACE1; m_prev = 2'd0; n_seen = 0;
      end else if (lsif.spawn_valid && lsif.spawn_ready) begin
         m_exp = m[1:0];
`ifdef NOTE_SPAWNER_NO_REPEAT_EN
         if (m_exp == m_prev) m_exp = m_exp + 2'd1;
         if (n_seen > 0 && lsif.spawn_lane == last_lane) lane_bad++;
`endif
         if (lsif.spawn_lane != m_exp) lane_bad++;
         m_prev    = m_exp;
         last_lane = lsif.spawn_lane;
         m         = {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
         n_seen++;
      end
   end

   initial begin
      logic exp_v;
      int   k;
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; difficulty = 2'b00;
      sif.spawn_ready = 1'b0; l_start = 1'b0; lsif.spawn_ready = 1'b1;
      #12;
      chk("rst_valid", sif.spawn_valid, 0);
      chk("rst_lane", sif.spawn_lane, 0);
      chk("rst_count", spawn_count, 0);
      chk("rst_active", active, 0);
      chk("rst_done", done, 0);
      @(negedge clk); rst_n = 1'b1;
      tick();

      // EASY, ready held high: pulses at edges 8..40
      sif.spawn_ready = 1'b1;
      run_start(2'b00);
      chk("e_active0", active, 1);
      chk("e_cnt0", spawn_count, 0);
      k = 0;
      for (int e = 1; e <= 41; e++) begin
         tick();
         exp_v = (e % 8 == 0) && (e <= 40);
         chk("e_valid", sif.spawn_valid, exp_v);
         if (exp_v) begin chk("e_lane", sif.spawn_lane, lanes[k]); k++; end
         chk("e_cnt", spawn_count, (e - 1) / 8);
      end
      chk("e_done", done, 1);
      chk("e_active", active, 0);

      // HARD; difficulty change mid-run must not alter spacing
      run_start(2'b10);
      difficulty = 2'b00;
      for (int e = 1; e <= 21; e++) begin
         tick();
         exp_v = (e % 4 == 0) && (e <= 20);
         chk("h_valid", sif.spawn_valid, exp_v);
      end
      chk("h_cnt", spawn_count, 5);
      chk("h_done", done, 1);

      // MEDIUM with a 3-cycle stall at the first offer
      sif.spawn_ready = 1'b0;
      run_start(2'b01);
      for (int e = 1; e <= 9; e++) begin
         tick();
         chk("m_valid", sif.spawn_valid, e >= 6);
         if (e >= 6) chk("m_lane_hold", sif.spawn_lane, lanes[0]);
         chk("m_cnt0", spawn_count, 0);
      end
      sif.spawn_ready = 1'b1;
      tick();
      chk("m_acc_valid", sif.spawn_valid, 0);
      chk("m_acc_cnt", spawn_count, 1);
      for (int e = 11; e <= 15; e++) begin
         tick();
         chk("m_valid2", sif.spawn_valid, e == 15);
      end
      chk("m_lane2", sif.spawn_lane, lanes[1]);

      // stop mid-handshake
      sif.spawn_ready = 1'b0;
      tick();
      chk("s_hold", sif.spawn_valid, 1);
      stop = 1'b1;
      #1;
      chk("s_drop_now", sif.spawn_valid, 0);
      tick();
      stop = 1'b0;
      #1;
      chk("s_valid", sif.spawn_valid, 0);
      chk("s_active", active, 0);
      chk("s_done", done, 0);
      chk("s_cnt_hold", spawn_count, 1);
      sif.spawn_ready = 1'b1;
      run_start(2'b01);
      chk("s_cnt_clr", spawn_count, 0);
      repeat (6) tick();
      chk("s_restart_valid", sif.spawn_valid, 1);
      chk("s_restart_lane", sif.spawn_lane, lanes[0]);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("s_stop_wins_cnt", spawn_count, 0);
      chk("s_idle", active, 0);

      // start and stop together from IDLE
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      chk("ss_active", active, 0);
      for (int e = 0; e < 8; e++) begin
         tick();
         chk("ss_valid", sif.spawn_valid, 0);
      end

      // async reset mid-WAIT after one accepted spawn
      run_start(2'b00);
      repeat (10) tick();
      chk("r_pre_cnt", spawn_count, 1);
      chk("r_pre_active", active, 1);
      rst_n = 1'b0;
      #2;
      chk("r_active", active, 0);
      chk("r_cnt", spawn_count, 0);
      chk("r_valid", sif.spawn_valid, 0);
      chk("r_done", done, 0);
      @(negedge clk); rst_n = 1'b1;
      tick();
      run_start(2'b00);
      repeat (8) tick();
      chk("r_lane", sif.spawn_lane, lanes[0]);
      chk("r_valid2", sif.spawn_valid, 1);

      // 1000-event HARD run on the long instance
      l_start = 1'b1;
      tick();
      l_start = 1'b0;
      for (int i = 0; i < 6000 && !l_done; i++) tick();
      chk("l_done", l_done, 1);
      chk("l_count", l_count, 1000);
      chk("l_seen", n_seen, 1000);
      chk("l_lane_bad", lane_bad, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
